// File: rtl/raw10_csi_packer.sv
// RAW10 4-pixel beats packed into CSI-2 RAW10 byte order and regridded from
// 5-byte groups onto a 32-bit stream; each line end is flushed to a word boundary.
module raw10_csi_packer (
  input  logic        I_clk,
  input  logic        I_rst_n,
  input  logic [39:0] I_pix_tdata,
  input  logic        I_pix_tvalid,
  output logic        I_pix_tready,
  input  logic        I_pix_tlast,
  input  logic        I_pix_tuser,
  output logic [31:0] O_csi_tdata,
  output logic [3:0]  O_csi_tkeep,
  output logic        O_csi_tvalid,
  input  logic        O_csi_tready,
  output logic        O_csi_tlast,
  output logic        O_csi_tuser
);

  logic [63:0] buf_q, buf_d, buf_p;
  logic [3:0]  occ_q, occ_d, occ_p;
  logic        flush_q, flush_d;
  logic        sof_q, sof_d;
  logic [39:0] group;
  logic [4:0]  keep_mask;
  logic        in_fire, out_fire;

  // B0..B3 carry the pixel MSBs, B4 gathers the four 2-bit LSB pairs
  assign group = {I_pix_tdata[31:30], I_pix_tdata[21:20], I_pix_tdata[11:10], I_pix_tdata[1:0],
                  I_pix_tdata[39:32], I_pix_tdata[29:22], I_pix_tdata[19:12], I_pix_tdata[9:2]};

  assign O_csi_tvalid = (occ_q >= 4'd4) | (flush_q & (occ_q != 4'd0));
  assign O_csi_tlast  = O_csi_tvalid & flush_q & (occ_q <= 4'd4);
  assign O_csi_tuser  = sof_q & O_csi_tvalid;
  assign O_csi_tdata  = buf_q[31:0];
  assign keep_mask    = (5'd1 << occ_q) - 5'd1;

  always_comb begin
    O_csi_tkeep = 4'h0;
    if (O_csi_tvalid) begin
      O_csi_tkeep = O_csi_tlast ? keep_mask[3:0] : 4'hF;
    end
  end

  // Accepting while a word leaves is only safe when at most 3 bytes remain after it
  assign I_pix_tready = !flush_q &
                        ((occ_q <= 4'd3) | (O_csi_tready & O_csi_tvalid & (occ_q <= 4'd7)));

  assign in_fire  = I_pix_tvalid & I_pix_tready;
  assign out_fire = O_csi_tvalid & O_csi_tready;

  always_comb begin
    occ_p = occ_q;
    buf_p = buf_q;
    if (out_fire) begin
      occ_p = (occ_q >= 4'd4) ? occ_q - 4'd4 : 4'd0;
      buf_p = buf_q >> 32;
    end

    buf_d = buf_p;
    occ_d = occ_p;
    if (in_fire) begin
      buf_d = buf_p | ({24'd0, group} << {occ_p, 3'b000});
      occ_d = occ_p + 4'd5;
    end

    flush_d = flush_q;
    if (in_fire && I_pix_tlast) begin
      flush_d = 1'b1;
    end else if (out_fire && O_csi_tlast) begin
      flush_d = 1'b0;
    end

    // A new SOF wins over the clear from a word leaving in the same cycle
    sof_d = sof_q;
    if (in_fire && I_pix_tuser) begin
      sof_d = 1'b1;
    end else if (out_fire) begin
      sof_d = 1'b0;
    end
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      buf_q   <= 64'd0;
      occ_q   <= 4'd0;
      flush_q <= 1'b0;
      sof_q   <= 1'b0;
    end else begin
      buf_q   <= buf_d;
      occ_q   <= occ_d;
      flush_q <= flush_d;
      sof_q   <= sof_d;
    end
  end

endmodule

// File: tb/tb_raw10_csi_packer.sv
// Bench for raw10_csi_packer: random pixels and backpressure checked against a
// byte-queue model of CSI-2 RAW10 packing and word regridding.
module tb_raw10_csi_packer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [39:0] pix_tdata;
  logic        pix_tvalid, pix_tready, pix_tlast, pix_tuser;
  logic [31:0] csi_tdata;
  logic [3:0]  csi_tkeep;
  logic        csi_tvalid, csi_tready, csi_tlast, csi_tuser;

  always #5 clk = ~clk;

  raw10_csi_packer dut (
    .I_clk       (clk),
    .I_rst_n     (rst_n),
    .I_pix_tdata (pix_tdata),
    .I_pix_tvalid(pix_tvalid),
    .I_pix_tready(pix_tready),
    .I_pix_tlast (pix_tlast),
    .I_pix_tuser (pix_tuser),
    .O_csi_tdata (csi_tdata),
    .O_csi_tkeep (csi_tkeep),
    .O_csi_tvalid(csi_tvalid),
    .O_csi_tready(csi_tready),
    .O_csi_tlast (csi_tlast),
    .O_csi_tuser (csi_tuser)
  );

  typedef struct {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
    logic        user;
  } word_t;

  int    n_tests = 0;
  int    n_fail  = 0;
  int    cyc     = 0;
  int    stall_cnt = 0;
  bit    stall_en  = 0;
  bit    bp_en     = 0;
  bit    sof_mark  = 0;
  int    first_acc, last_acc;
  word_t exp_q[$];
  word_t got_q[$];
  int    tlast_edges[$];
  logic [7:0] line_bytes[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Downstream ready, optionally random
  initial begin
    csi_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      csi_tready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Model: pixels -> byte stream -> 4-byte words, line tail padded with zeros
  task automatic emit_word(input int n, input bit last);
    word_t w;
    w.data = 32'd0;
    for (int j = 0; j < n; j++) w.data[8*j +: 8] = line_bytes.pop_front();
    w.keep = 4'((1 << n) - 1);
    w.last = last;
    w.user = sof_mark;
    sof_mark = 0;
    exp_q.push_back(w);
  endtask

  task automatic model_beat(input logic [39:0] d, input bit last, input bit user);
    int lsbs = 0;
    if (user) sof_mark = 1;
    for (int i = 0; i < 4; i++) begin
      int p = int'(d[10*i +: 10]);
      line_bytes.push_back(8'(p / 4));
      lsbs += (p % 4) << (2 * i);
    end
    line_bytes.push_back(8'(lsbs));
    while (line_bytes.size() > 4 || (line_bytes.size() == 4 && !last)) emit_word(4, 0);
    if (last) emit_word(line_bytes.size(), 1);
  endtask

  // Monitor: scoreboard compare and hold-stability under backpressure
  bit    hold_prev = 0;
  word_t prev_w;
  always @(negedge clk) begin
    word_t cur, e;
    if (!rst_n) begin
      hold_prev = 0;
    end else begin
      cur = '{csi_tdata, csi_tkeep, csi_tlast, csi_tuser};
      if (hold_prev) begin
        check_eq("hold_valid", csi_tvalid, 1'b1);
        check_eq("hold_data", cur.data, prev_w.data);
        check_eq("hold_keep", cur.keep, prev_w.keep);
        check_eq("hold_last", cur.last, prev_w.last);
        check_eq("hold_user", cur.user, prev_w.user);
      end
      if (csi_tvalid && csi_tready) begin
        got_q.push_back(cur);
        if (csi_tlast) tlast_edges.push_back(cyc + 1);
        if (exp_q.size() == 0) begin
          check_eq("extra_word", cur.data, 64'hDEAD_0000_0000);
        end else begin
          e = exp_q.pop_front();
          check_eq("word_data", cur.data, e.data);
          check_eq("word_keep", cur.keep, e.keep);
          check_eq("word_last", cur.last, e.last);
          check_eq("word_user", cur.user, e.user);
        end
      end
      if (stall_en && !pix_tready) stall_cnt++;
      hold_prev = csi_tvalid && !csi_tready;
      prev_w = cur;
    end
  end

  task automatic push_beat(input logic [39:0] d, input bit last, input bit user);
    bit ok = 0;
    int guard = 0;
    pix_tdata = d;
    pix_tlast = last;
    pix_tuser = user;
    pix_tvalid = 1'b1;
    while (!ok && guard < 500) begin
      @(negedge clk);
      ok = pix_tready;
      guard++;
      @(posedge clk);
      #1;
    end
    pix_tvalid = 1'b0;
    pix_tlast = 1'b0;
    pix_tuser = 1'b0;
    if (!ok) begin
      check_eq("beat_accept_timeout", 0, 1);
    end else begin
      last_acc = cyc;
      model_beat(d, last, user);
    end
  endtask

  task automatic send_line(input int n, input bit sof);
    logic [39:0] d;
    for (int i = 0; i < n; i++) begin
      d = {8'($urandom), 32'($urandom)};
      push_beat(d, i == n - 1, sof && i == 0);
      if (i == 0) begin
        first_acc = last_acc;
        stall_en = 1;
      end
    end
    stall_en = 0;
  endtask

  task automatic drain();
    int guard = 0;
    while ((exp_q.size() != 0 || csi_tvalid) && guard < 4000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    check_eq("drain_timeout", guard >= 4000, 0);
  endtask

  task automatic check_ref_line(input string tag);
    check_eq({tag, "_words"}, got_q.size(), 2);
    if (got_q.size() == 2) begin
      check_eq({tag, "_w0_data"}, got_q[0].data, 32'h00FF4080);
      check_eq({tag, "_w0_keep"}, got_q[0].keep, 4'hF);
      check_eq({tag, "_w0_user"}, got_q[0].user, 1'b1);
      check_eq({tag, "_w0_last"}, got_q[0].last, 1'b0);
      check_eq({tag, "_w1_data"}, got_q[1].data, 32'h000000C9);
      check_eq({tag, "_w1_keep"}, got_q[1].keep, 4'h1);
      check_eq({tag, "_w1_last"}, got_q[1].last, 1'b1);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

  initial begin
    int ucnt;
    logic [39:0] ref_beat;
    ref_beat = {10'h003, 10'h3FC, 10'h102, 10'h201};
    rst_n = 1'b0;
    pix_tdata = '0;
    pix_tvalid = 1'b0;
    pix_tlast = 1'b0;
    pix_tuser = 1'b0;
    #1;
    check_eq("rst_tvalid", csi_tvalid, 1'b0);
    check_eq("rst_tdata", csi_tdata, 32'd0);
    check_eq("rst_tkeep", csi_tkeep, 4'd0);
    check_eq("rst_tlast", csi_tlast, 1'b0);
    check_eq("rst_tuser", csi_tuser, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_eq("rst_tready", pix_tready, 1'b1);
    @(posedge clk);
    #1;

    // Single-beat line with SOF
    got_q.delete();
    push_beat(ref_beat, 1, 1);
    check_eq("latency_valid", csi_tvalid, 1'b1);
    check_eq("flush_stall", pix_tready, 1'b0);
    drain();
    check_ref_line("single");

    // Four-beat and eight-beat lines, no backpressure
    got_q.delete();
    tlast_edges.delete();
    stall_cnt = 0;
    send_line(4, 0);
    drain();
    check_eq("l4_words", got_q.size(), 5);
    check_eq("l4_feed_stalls", stall_cnt, 0);
    if (got_q.size() == 5) begin
      for (int i = 0; i < 5; i++) check_eq("l4_keep", got_q[i].keep, 4'hF);
      check_eq("l4_last4", got_q[4].last, 1'b1);
      check_eq("l4_last3", got_q[3].last, 1'b0);
    end
    if (tlast_edges.size() == 1) check_eq("l4_tlast_edge", tlast_edges[0] - first_acc, 5);
    else check_eq("l4_tlast_count", tlast_edges.size(), 1);

    got_q.delete();
    stall_cnt = 0;
    send_line(8, 0);
    drain();
    check_eq("l8_words", got_q.size(), 10);
    check_eq("l8_feed_stalls", stall_cnt, 1);

    // Back-to-back 3-beat and 2-beat lines
    got_q.delete();
    tlast_edges.delete();
    send_line(3, 0);
    send_line(2, 0);
    drain();
    check_eq("b2b_words", got_q.size(), 7);
    if (got_q.size() == 7) begin
      check_eq("b2b_l1_last", got_q[3].last, 1'b1);
      check_eq("b2b_l1_keep", got_q[3].keep, 4'h7);
      check_eq("b2b_l2_last", got_q[6].last, 1'b1);
      check_eq("b2b_l2_keep", got_q[6].keep, 4'h3);
    end
    if (tlast_edges.size() == 2) check_eq("b2b_l2_start", first_acc, tlast_edges[0] + 1);
    else check_eq("b2b_tlast_count", tlast_edges.size(), 2);

    // 1920-pixel line under random backpressure
    got_q.delete();
    bp_en = 1;
    send_line(480, 0);
    drain();
    bp_en = 0;
    check_eq("bp_words", got_q.size(), 600);
    ucnt = 0;
    foreach (got_q[i]) if (got_q[i].last) ucnt++;
    check_eq("bp_tlast_count", ucnt, 1);
    @(posedge clk);
    #1;

    // Asynchronous reset mid-line
    push_beat({8'($urandom), 32'($urandom)}, 0, 1);
    push_beat({8'($urandom), 32'($urandom)}, 0, 0);
    check_eq("mid_valid_before", csi_tvalid, 1'b1);
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_tvalid", csi_tvalid, 1'b0);
    check_eq("mid_rst_tdata", csi_tdata, 32'd0);
    check_eq("mid_rst_tkeep", csi_tkeep, 4'd0);
    check_eq("mid_rst_tlast", csi_tlast, 1'b0);
    check_eq("mid_rst_tuser", csi_tuser, 1'b0);
    exp_q.delete();
    line_bytes.delete();
    sof_mark = 0;
    @(negedge clk);
    rst_n = 1'b1;
    check_eq("mid_rst_tready", pix_tready, 1'b1);
    @(posedge clk);
    #1;
    got_q.delete();
    push_beat(ref_beat, 1, 1);
    drain();
    check_ref_line("after_rst");

    // Two-line frame, SOF only on the first beat
    got_q.delete();
    send_line(2, 1);
    send_line(3, 0);
    drain();
    ucnt = 0;
    foreach (got_q[i]) if (got_q[i].user) ucnt++;
    check_eq("frame_user_count", ucnt, 1);
    if (got_q.size() > 0) check_eq("frame_user_first", got_q[0].user, 1'b1);
    else check_eq("frame_words", got_q.size(), 7);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
